// File: rtl/mul_op_unit_pkg.sv
// Shared constants for the multiplier datapath: control-word and condition-bit indices.
// Also holds the operand magnitude helper used by the operand registers.
package mul_op_pkg;

  localparam int YW = 12;
  localparam int PW = 10;

  localparam int N_DEF = 8;

  localparam int Y_LD_A  = 0;
  localparam int Y_LD_B  = 1;
  localparam int Y_CLR   = 2;
  localparam int Y_SIGN  = 3;
  localparam int Y_MAG_A = 4;
  localparam int Y_MAG_B = 5;
  localparam int Y_ADD   = 6;
  localparam int Y_SHR   = 7;
  localparam int Y_DEC   = 8;
  localparam int Y_RES   = 9;
  localparam int Y_ACK   = 10;
  localparam int Y_CLR_V = 11;

  localparam int P_B0    = 0;
  localparam int P_CNT0  = 1;
  localparam int P_AZ    = 2;
  localparam int P_BZ    = 3;
  localparam int P_SIGN  = 4;
  localparam int P_AMSB  = 5;
  localparam int P_BMSB  = 6;
  localparam int P_C     = 7;
  localparam int P_VALID = 8;
  localparam int P_START = 9;

  typedef logic [N_DEF-1:0] opnd_t;

  // Two's complement to unsigned magnitude; the most negative value
  // maps onto its own bit pattern, which reads as 2^(N-1) unsigned.
  function automatic opnd_t mag(input opnd_t v);
    return v[N_DEF-1] ? opnd_t'(-v) : v;
  endfunction

endpackage

// File: rtl/mul_op_unit_if.sv
// Control-unit <-> datapath bundle: control word and operands in, flags and product out.
interface mul_op_unit_if
  import mul_op_pkg::*;
#(
  parameter int N = N_DEF
);

  logic [YW-1:0]  y;
  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [PW-1:0]  p;
  logic [2*N-1:0] result;
  logic           result_valid;
  logic           err;

  modport master (
    output y, start, a_in, b_in,
    input  p, result, result_valid, err
  );

  modport slave (
    input  y, start, a_in, b_in,
    output p, result, result_valid, err
  );

endinterface

// File: rtl/mul_op_unit_cond.sv
// Condition vector p for the control unit, built purely from datapath register state.
module mul_op_cond
  import mul_op_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  ra_i,
  input  logic [N-1:0]  rb_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          c_i,
  input  logic          sign_i,
  input  logic          valid_i,
  input  logic          start_i,
  output logic [PW-1:0] p_o
);

  always_comb begin
    p_o          = '0;
    p_o[P_B0]    = rb_i[0];
    p_o[P_CNT0]  = (cnt_i == '0);
    p_o[P_AZ]    = (ra_i == '0);
    p_o[P_BZ]    = (rb_i == '0);
    p_o[P_SIGN]  = sign_i;
    p_o[P_AMSB]  = ra_i[N-1];
    p_o[P_BMSB]  = rb_i[N-1];
    p_o[P_C]     = c_i;
    p_o[P_VALID] = valid_i;
    p_o[P_START] = start_i;
  end

endmodule

// File: rtl/mul_op_unit.sv
// Signed shift-and-add multiplier datapath driven by a 12-bit microprogram word.
// Define OPU_ILLEGAL_CHK_EN to build the sticky illegal-control-word flag (err).
module mul_op_unit
  import mul_op_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_op_unit_if.slave bus
);

  logic [YW-1:0] y;
  assign y = bus.y;

  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [2*N-1:0] rc_q, rc_d;
  logic           c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [2*N-1:0] res_q, res_d;
  logic           rv_q, rv_d;
  logic           st_q, st_d;
  logic [N:0]     sum;

  assign sum = {1'b0, rc_q[2*N-1:N]} + {1'b0, ra_q};

  always_comb begin
    ra_d   = ra_q;
    rb_d   = rb_q;
    rc_d   = rc_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    res_d  = res_q;
    rv_d   = rv_q;
    st_d   = st_q;

    if (y[Y_LD_A])
      ra_d = bus.a_in;
    else if (y[Y_MAG_A])
      ra_d = mag(ra_q);

    // an add on the same edge swallows the whole shift step
    if (y[Y_LD_B])
      rb_d = bus.b_in;
    else if (y[Y_MAG_B])
      rb_d = mag(rb_q);
    else if (y[Y_SHR] && !y[Y_ADD])
      rb_d = rb_q >> 1;

    if (y[Y_CLR]) begin
      rc_d = '0;
      c_d  = 1'b0;
    end else if (y[Y_ADD]) begin
      rc_d[2*N-1:N] = sum[N-1:0];
      c_d           = sum[N];
    end else if (y[Y_SHR]) begin
      rc_d = {c_q, rc_q[2*N-1:1]};
      c_d  = 1'b0;
    end else if (y[Y_CLR_V]) begin
      c_d = 1'b0;
    end

    if (y[Y_CLR])
      cnt_d = CW'(N);
    else if (y[Y_DEC] && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;

    if (y[Y_SIGN])
      sign_d = ra_q[N-1] ^ rb_q[N-1];

    if (y[Y_RES]) begin
      res_d = sign_q ? -rc_q : rc_q;
      rv_d  = 1'b1;
    end else if (y[Y_CLR_V]) begin
      rv_d = 1'b0;
    end

    if (y[Y_ACK])
      st_d = 1'b0;
    else if (bus.start)
      st_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      rv_q   <= 1'b0;
      st_q   <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rc_q   <= rc_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      res_q  <= res_d;
      rv_q   <= rv_d;
      st_q   <= st_d;
    end
  end

`ifdef OPU_ILLEGAL_CHK_EN
  logic err_q;
  logic illegal;

  assign illegal = (y[Y_LD_A] & y[Y_MAG_A])
                 | (y[Y_LD_B] & y[Y_MAG_B])
                 | (y[Y_ADD]  & y[Y_SHR])
                 | (y[Y_CLR]  & y[Y_ADD])
                 | (y[Y_RES]  & y[Y_CLR_V]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (illegal)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.result       = res_q;
  assign bus.result_valid = rv_q;

  mul_op_cond #(
    .N  (N),
    .CW (CW)
  ) u_cond (
    .ra_i    (ra_q),
    .rb_i    (rb_q),
    .cnt_i   (cnt_q),
    .c_i     (c_q),
    .sign_i  (sign_q),
    .valid_i (rv_q),
    .start_i (st_q),
    .p_o     (bus.p)
  );

endmodule

// File: tb/tb_mul_op_unit.sv
// Scoreboard bench for mul_op_unit: products predicted with integer arithmetic,
// checked by an independent monitor on each rising result_valid.
module tb_mul_op_unit;
  import mul_op_pkg::*;

  localparam int N = 8;

`ifdef OPU_ILLEGAL_CHK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mul_op_unit_if #(.N(N)) bus ();

  mul_op_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [2*N-1:0] expq[$];
  logic rv_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [YW-1:0] yb(input int i);
    logic [YW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: every rising result_valid consumes one expected product
  initial begin
    forever begin
      @(negedge clk);
      if (bus.result_valid && !rv_prev) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          logic [2*N-1:0] e;
          e = expq.pop_front();
          chk("result", int'(bus.result), int'(e));
        end
      end
      rv_prev = bus.result_valid;
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, ma, mb, prod;
    logic [2*N-1:0] ep;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    prod = sa * sb;
    ep = prod[2*N-1:0];

    bus.a_in = a;
    bus.b_in = b;
    bus.start = 1'b1;
    bus.y = yb(Y_LD_A) | yb(Y_LD_B);
    tick();
    bus.start = 1'b0;
    chk("start_latched", int'(bus.p[P_START]), 1);
    chk("b_msb", int'(bus.p[P_BMSB]), int'(b[N-1]));

    bus.y = yb(Y_SIGN);
    tick();
    chk("sign", int'(bus.p[P_SIGN]), ((sa < 0) != (sb < 0)) ? 1 : 0);
    chk("a_msb", int'(bus.p[P_AMSB]), int'(a[N-1]));

    bus.y = yb(Y_MAG_A) | yb(Y_MAG_B) | yb(Y_CLR);
    tick();
    chk("a_zero", int'(bus.p[P_AZ]), (ma == 0) ? 1 : 0);
    chk("b_zero", int'(bus.p[P_BZ]), (mb == 0) ? 1 : 0);
    chk("a_mag_msb", int'(bus.p[P_AMSB]), (ma >= 128) ? 1 : 0);
    chk("cnt_loaded", int'(bus.p[P_CNT0]), 0);

    for (int i = 0; i < N; i++) begin
      chk("b_bit", int'(bus.p[P_B0]), (mb >> i) & 1);
      if (bus.p[P_B0]) begin
        bus.y = yb(Y_ADD);
        tick();
      end
      bus.y = yb(Y_SHR) | yb(Y_DEC);
      tick();
    end
    chk("cnt_done", int'(bus.p[P_CNT0]), 1);
    chk("carry_end", int'(bus.p[P_C]), 0);

    expq.push_back(ep);
    bus.y = yb(Y_RES) | yb(Y_ACK);
    tick();
    chk("valid_set", int'(bus.p[P_VALID]), 1);
    chk("start_acked", int'(bus.p[P_START]), 0);

    bus.y = yb(Y_CLR_V);
    tick();
    chk("valid_clr", int'(bus.result_valid), 0);
    bus.y = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1);
  end

  initial begin
    bus.y = '0;
    bus.start = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;

    #1;
    chk("reset_p", int'(bus.p), 'b0000001110);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_valid", int'(bus.result_valid), 0);
    chk("reset_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd3, 8'd5);
    run_op(8'hFD, 8'd5);
    run_op(8'h80, 8'h80);
    run_op(8'h00, 8'h7F);
    run_op(8'h7F, 8'h80);
    run_op(8'hFF, 8'hFF);
    for (int k = 0; k < 20; k++)
      run_op(8'($urandom), 8'($urandom));

    // idle edge holds everything
    bus.y = '0;
    tick();
    chk("idle_valid", int'(bus.result_valid), 0);
    chk("idle_cnt", int'(bus.p[P_CNT0]), 1);

    // start and acknowledge on the same edge: ack wins
    bus.start = 1'b1;
    tick();
    chk("start_only", int'(bus.p[P_START]), 1);
    bus.y = yb(Y_ACK);
    tick();
    chk("start_vs_ack", int'(bus.p[P_START]), 0);
    bus.start = 1'b0;
    bus.y = '0;

    // add and shift together: only the add happens, RB untouched
    bus.a_in = 8'h10;
    bus.b_in = 8'h07;
    bus.y = yb(Y_LD_A) | yb(Y_LD_B);
    tick();
    bus.y = yb(Y_SIGN) | yb(Y_CLR);
    tick();
    bus.y = yb(Y_ADD) | yb(Y_SHR);
    tick();
    chk("conflict_rb0", int'(bus.p[P_B0]), 1);
    chk("conflict_c", int'(bus.p[P_C]), 0);
    chk("conflict_err", int'(bus.err), ERR_EXP);
    bus.y = yb(Y_SHR);
    tick();
    chk("shift_rb0", int'(bus.p[P_B0]), 1);
    chk("err_sticky", int'(bus.err), ERR_EXP);
    expq.push_back(16'h0800);
    bus.y = yb(Y_RES);
    tick();
    bus.y = yb(Y_CLR_V);
    tick();
    bus.y = '0;

    // abort mid-iteration with an asynchronous reset
    bus.start = 1'b1;
    bus.a_in = 8'h55;
    bus.b_in = 8'h33;
    bus.y = yb(Y_LD_A) | yb(Y_LD_B);
    tick();
    bus.start = 1'b0;
    bus.y = yb(Y_SIGN);
    tick();
    bus.y = yb(Y_MAG_A) | yb(Y_MAG_B) | yb(Y_CLR);
    tick();
    bus.y = yb(Y_ADD);
    tick();
    bus.y = yb(Y_SHR) | yb(Y_DEC);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_p", int'(bus.p), 'b0000001110);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_valid", int'(bus.result_valid), 0);
    chk("abort_err", int'(bus.err), 0);
    bus.y = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_start", int'(bus.p[P_START]), 0);

    run_op(8'hF9, 8'h0B);

    repeat (2) tick();
    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
